// File: rtl/imem_loader.sv
// Serial image loader for the 2048x16 instruction memory.
// Ports: clk/rst, rx_data/rx_rdy byte stream in; we/waddr/wdata memory
// write port, cpu_hold CPU reset hold, done/err load status levels out.
module imem_loader #(
  parameter int unsigned ADDR_W      = 11,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_rdy,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [15:0]       wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned CW   = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        sum_q, sum_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     len_q, len_d;
  logic [7:0]        lenhi_q, lenhi_d;
  logic [7:0]        hi_q, hi_d;

  logic [15:0]       len_full;
  logic              len_bad;
  logic              in_frame;
  logic [CW-1:0]     cnt_inc;

  assign len_full = {lenhi_q, rx_data};
  assign len_bad  = (len_full == 16'd0) ||
                    (32'(len_full) > (32'd1 << ADDR_W));
  assign cnt_inc  = cnt_q + 1'b1;
  assign in_frame = (state_q == S_LEN_HI)  ||
                    (state_q == S_LEN_LO)  ||
                    (state_q == S_DATA_HI) ||
                    (state_q == S_DATA_LO) ||
                    (state_q == S_CHK);

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    sum_d   = sum_q;
    to_d    = to_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    lenhi_d = lenhi_q;
    hi_d    = hi_q;

    // Address advances on the edge that ends the write pulse, so it is
    // stable for the whole we cycle. Wraps naturally after a full image.
    if (we_q) waddr_d = waddr_q + 1'b1;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (rx_rdy && rx_data == SYNC_BYTE) begin
          state_d = S_LEN_HI;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          sum_d   = 8'd0;
          waddr_d = '0;
          cnt_d   = '0;
        end
      end
      S_LEN_HI: begin
        if (rx_rdy) begin
          lenhi_d = rx_data;
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (rx_rdy) begin
          if (len_bad) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            len_d   = CW'(len_full);
            state_d = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (rx_rdy) begin
          hi_d    = rx_data;
          sum_d   = sum_q + rx_data;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (rx_rdy) begin
          sum_d   = sum_q + rx_data;
          we_d    = 1'b1;
          wdata_d = {hi_q, rx_data};
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == len_q) ? S_CHK : S_DATA_HI;
        end
      end
      S_CHK: begin
        if (rx_rdy) begin
          if (rx_data == sum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte watchdog; only byte handling above can move the FSM on an
    // rx_rdy cycle, so the expiry branch never competes with it.
    if (in_frame) begin
      if (rx_rdy) begin
        to_d = '0;
      end else if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
        to_d    = '0;
        state_d = S_ERR;
        err_d   = 1'b1;
      end else begin
        to_d = to_q + 1'b1;
      end
    end else begin
      to_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sum_q   <= '0;
      to_q    <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      lenhi_q <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sum_q   <= sum_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      lenhi_q <= lenhi_d;
      hi_q    <= hi_d;
    end
  end

  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign cpu_hold = hold_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
